// File: rtl/sobel_edge_detect.sv
// sobel_edge_detect: 3x3 Sobel magnitude and threshold on a luma stream.
// Five register stages from input to output; sync signals are delayed to match.
module sobel_edge_detect #(
    parameter int          LINE_MAX  = 1024,
    parameter logic [10:0] THRESHOLD = 11'd160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_hsync,
    input  logic        pre_frame_de,
    input  logic [7:0]  pre_img_y,
    output logic        post_frame_vsync,
    output logic        post_frame_hsync,
    output logic        post_frame_de,
    output logic        post_edge_bit,
    output logic [23:0] post_img_data
);

    localparam int          AW   = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
    localparam logic [10:0] LMAX = 11'(LINE_MAX);

    logic [10:0]   col_cnt;
    logic [10:0]   row_cnt;
    logic [10:0]   row_cur;
    logic          vs_d;
    logic          de_d;
    logic          vs_rise;
    logic          de_fall;
    logic          in_line;
    logic          valid_in;
    logic [AW-1:0] addr;

    logic [4:0]    vs_sr;
    logic [4:0]    hs_sr;
    logic [4:0]    de_sr;

    logic [7:0]    lb1 [LINE_MAX];
    logic [7:0]    lb2 [LINE_MAX];

    logic [7:0]    y1;
    logic [7:0]    top1;
    logic [7:0]    mid1;
    logic          v1;
    logic [7:0]    w [3][3];
    logic          v2;
    logic [9:0]    col_l;
    logic [9:0]    col_r;
    logic [9:0]    row_t;
    logic [9:0]    row_b;
    logic signed [11:0] gx_c;
    logic signed [11:0] gy_c;
    logic signed [11:0] gx;
    logic signed [11:0] gy;
    logic          v3;
    logic [9:0]    ax;
    logic [9:0]    ay;
    logic [10:0]   mag;
    logic          v4;
    logic          edge_q;

    // A vsync rise wins over the stored row, so its own pixel is row 0.
    assign vs_rise  = pre_frame_vsync & ~vs_d;
    assign de_fall  = de_d & ~pre_frame_de;
    assign row_cur  = vs_rise ? 11'd0 : row_cnt;
    assign in_line  = col_cnt < LMAX;
    assign addr     = col_cnt[AW-1:0];
    assign valid_in = pre_frame_de && (row_cur >= 11'd2)
                      && (col_cnt >= 11'd2) && in_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
            vs_d    <= 1'b0;
            de_d    <= 1'b0;
        end else begin
            vs_d <= pre_frame_vsync;
            de_d <= pre_frame_de;
            if (!pre_frame_de) begin
                col_cnt <= '0;
            end else if (in_line) begin
                col_cnt <= col_cnt + 11'd1;
            end
            if (vs_rise) begin
                row_cnt <= '0;
            end else if (de_fall && (row_cnt != 11'h7FF)) begin
                row_cnt <= row_cnt + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sr <= '0;
            hs_sr <= '0;
            de_sr <= '0;
        end else begin
            vs_sr <= {vs_sr[3:0], pre_frame_vsync};
            hs_sr <= {hs_sr[3:0], pre_frame_hsync};
            de_sr <= {de_sr[3:0], pre_frame_de};
        end
    end

    // Line storage is not reset; the row/column border rule masks it.
    always_ff @(posedge clk) begin
        if (pre_frame_de && in_line) begin
            lb1[addr] <= pre_img_y;
            lb2[addr] <= lb1[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1   <= '0;
            top1 <= '0;
            mid1 <= '0;
            v1   <= 1'b0;
        end else begin
            y1   <= pre_img_y;
            top1 <= lb2[addr];
            mid1 <= lb1[addr];
            v1   <= valid_in;
        end
    end

    // de_sr[0] is the registered de that belongs to the S1 sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w[r][c] <= '0;
                end
            end
            v2 <= 1'b0;
        end else begin
            if (de_sr[0]) begin
                for (int r = 0; r < 3; r++) begin
                    w[r][0] <= w[r][1];
                    w[r][1] <= w[r][2];
                end
                w[0][2] <= top1;
                w[1][2] <= mid1;
                w[2][2] <= y1;
            end
            v2 <= v1 & de_sr[0];
        end
    end

    always_comb begin
        col_l = {2'b00, w[0][0]} + {1'b0, w[1][0], 1'b0} + {2'b00, w[2][0]};
        col_r = {2'b00, w[0][2]} + {1'b0, w[1][2], 1'b0} + {2'b00, w[2][2]};
        row_t = {2'b00, w[0][0]} + {1'b0, w[0][1], 1'b0} + {2'b00, w[0][2]};
        row_b = {2'b00, w[2][0]} + {1'b0, w[2][1], 1'b0} + {2'b00, w[2][2]};
        gx_c  = $signed({2'b00, col_r}) - $signed({2'b00, col_l});
        gy_c  = $signed({2'b00, row_t}) - $signed({2'b00, row_b});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx <= '0;
            gy <= '0;
            v3 <= 1'b0;
        end else begin
            gx <= gx_c;
            gy <= gy_c;
            v3 <= v2;
        end
    end

    // Each |G| is at most 1020, so 10 bits hold it and the sum fits 11.
    assign ax = gx[11] ? 10'(-gx) : 10'(gx);
    assign ay = gy[11] ? 10'(-gy) : 10'(gy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag    <= '0;
            v4     <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            mag    <= {1'b0, ax} + {1'b0, ay};
            v4     <= v3;
            edge_q <= v4 && (mag >= THRESHOLD);
        end
    end

    assign post_frame_vsync = vs_sr[4];
    assign post_frame_hsync = hs_sr[4];
    assign post_frame_de    = de_sr[4];
    assign post_edge_bit    = edge_q & de_sr[4];
    assign post_img_data    = {24{post_edge_bit}};

endmodule

// File: tb/tb_sobel_edge_detect.sv
// tb_sobel_edge_detect: directed frames with hand-derived edge rectangles.
// Small LINE_MAX so that overlong lines and full frames stay short.
module tb_sobel_edge_detect;

    localparam int LM = 16;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int LONG_LEN = 22;

    typedef struct {
        int kind;
        int pos;
        int lo;
        int hi;
        int long_row;
        int er0;
        int er1;
        int ec0;
        int ec1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        hsync = 1'b0;
    logic        de = 1'b0;
    logic [7:0]  y = 8'd0;
    logic        post_frame_vsync;
    logic        post_frame_hsync;
    logic        post_frame_de;
    logic        post_edge_bit;
    logic [23:0] post_img_data;

    logic [4:0]  h_vs = '0;
    logic [4:0]  h_hs = '0;
    logic [4:0]  h_de = '0;
    logic [4:0]  h_ed = '0;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t tv [11];
    vec_t v2s;

    sobel_edge_detect #(
        .LINE_MAX (LM),
        .THRESHOLD(11'd160)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pre_frame_vsync (vsync),
        .pre_frame_hsync (hsync),
        .pre_frame_de    (de),
        .pre_img_y       (y),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_hsync(post_frame_hsync),
        .post_frame_de   (post_frame_de),
        .post_edge_bit   (post_edge_bit),
        .post_img_data   (post_img_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int exp_data;
        exp_data = h_ed[4] ? 32'h00FFFFFF : 0;
        check({tag, "_vsync"}, int'(post_frame_vsync), int'(h_vs[4]));
        check({tag, "_hsync"}, int'(post_frame_hsync), int'(h_hs[4]));
        check({tag, "_de"}, int'(post_frame_de), int'(h_de[4]));
        check({tag, "_edge"}, int'(post_edge_bit), int'(h_ed[4]));
        check({tag, "_data"}, int'(post_img_data), exp_data);
    endtask

    // One clock: drive, let the edge pass, then compare against history.
    task automatic step(input logic v, input logic h, input logic d,
                        input logic [7:0] yy, input logic e);
        vsync = v;
        hsync = h;
        de    = d;
        y     = yy;
        if (rst_n) begin
            h_vs = {h_vs[3:0], v};
            h_hs = {h_hs[3:0], h};
            h_de = {h_de[3:0], d};
            h_ed = {h_ed[3:0], e & d};
        end else begin
            h_vs = '0;
            h_hs = '0;
            h_de = '0;
            h_ed = '0;
        end
        @(posedge clk);
        #1;
        check_outputs("pix");
    endtask

    function automatic logic [7:0] pix(input vec_t v, input int r, input int c);
        case (v.kind)
            0:       return 8'(v.lo);
            1:       return (c < v.pos) ? 8'(v.lo) : 8'(v.hi);
            default: return (r < v.pos) ? 8'(v.lo) : 8'(v.hi);
        endcase
    endfunction

    function automatic logic exp_edge(input vec_t v, input int r, input int c);
        return (r >= v.er0) && (r <= v.er1) && (c >= v.ec0)
               && (c <= v.ec1) && (c < LM);
    endfunction

    // mode 0: vsync pulse first; 1: no vsync; 2: extra line whose de fall
    // meets the vsync rise; 3: vsync rises on column 2 of row 0.
    task automatic run_frame(input vec_t v, input int mode, input int abort_row);
        int len;
        logic vs;
        if (mode == 2) begin
            step(0, 1, 0, 0, 0);
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            for (int c = 0; c < W; c++) begin
                step(0, 0, 1, pix(v, v.er1, c), exp_edge(v, v.er1, c));
            end
            step(1, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end else if (mode == 0) begin
            step(1, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        for (int r = 0; r < H; r++) begin
            len = (r == v.long_row) ? LONG_LEN : W;
            step(0, 1, 0, 0, 0);
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            for (int c = 0; c < len; c++) begin
                if (r == abort_row && c == 7) return;
                vs = (mode == 3) && (r == 0) && (c == 2 || c == 3);
                step(vs, 0, 1, pix(v, r, c), exp_edge(v, r, c));
            end
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        repeat (3) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{0, 0, 128, 128, -1, 1, 0, 0, -1};
        tv[1]  = '{1, 8, 0, 255, -1, 2, 7, 8, 9};
        tv[2]  = '{1, 8, 255, 0, -1, 2, 7, 8, 9};
        tv[3]  = '{2, 4, 0, 255, -1, 4, 5, 2, 15};
        tv[4]  = '{1, 5, 0, 40, -1, 2, 7, 5, 6};
        tv[5]  = '{1, 5, 0, 39, -1, 1, 0, 0, -1};
        tv[6]  = '{2, 3, 100, 140, -1, 3, 4, 2, 15};
        tv[7]  = '{1, 8, 0, 255, 3, 2, 7, 8, 9};
        tv[8]  = '{1, 1, 0, 255, -1, 2, 7, 2, 2};
        tv[9]  = '{2, 1, 0, 255, -1, 2, 2, 2, 15};
        tv[10] = '{1, 15, 0, 255, -1, 2, 7, 15, 15};
        v2s    = '{1, 2, 0, 255, -1, 2, 7, 2, 3};

        // Reset held with random activity on every input.
        rst_n = 1'b0;
        repeat (8) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        end
        #2;
        rst_n = 1'b1;
        repeat (6) step(0, 0, 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            run_frame(tv[i], 0, -1);
        end

        run_frame(tv[1], 0, -1);
        run_frame(tv[1], 2, -1);
        run_frame(v2s, 0, -1);
        run_frame(v2s, 3, -1);

        // Asynchronous reset in the middle of row 5.
        run_frame(tv[1], 0, 5);
        #2;
        rst_n = 1'b0;
        h_vs = '0;
        h_hs = '0;
        h_de = '0;
        h_ed = '0;
        #1;
        check_outputs("async_rst");
        repeat (3) step(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        repeat (4) step(0, 0, 0, 0, 0);
        run_frame(tv[1], 1, -1);
        run_frame(tv[1], 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_edge_detect.md
Name: sobel_edge_detect

Overview:
- Consumes the 8-bit luma (Y) stream from the RGB-to-YCbCr stage, together with its vsync/hsync/de timing signals.
- Computes a 3x3 Sobel gradient magnitude for each pixel and compares it against a threshold.
- Emits a binary edge image as 24-bit pixels (0x000000 or 0xFFFFFF) with timing re-aligned to the data.
- Sits between the colour-space converter and the display/VGA output mux.

Parameters:
- LINE_MAX, 1024: line-buffer depth, i.e. maximum active pixels per line.
- THRESHOLD, 11'd160: gradient magnitude at or above which a pixel is an edge.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  async active-low reset
- pre_frame_vsync  input  1  frame sync, active high; frame starts on rising edge
- pre_frame_hsync  input  1  line sync
- pre_frame_de  input  1  pixel valid
- pre_img_y  input  8  luma sample, valid when pre_frame_de=1
- post_frame_vsync  output  1  vsync delayed by 5 clk
- post_frame_hsync  output  1  hsync delayed by 5 clk
- post_frame_de  output  1  de delayed by 5 clk
- post_edge_bit  output  1  1 = edge pixel
- post_img_data  output  24  {24{post_edge_bit}}

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs go to 0.
  - Sync delay lines, counters, window registers and pipeline registers clear.
  - Line-buffer contents are don't-care after reset; they are masked by the border rule.
- Counters:
  - col_cnt (11b) increments once per de=1 cycle and clears on the first cycle de=0.
  - row_cnt (11b) increments on each de falling edge and saturates at 2047.
  - row_cnt clears on the vsync rising edge, detected by a 1-cycle-registered compare.
- Line buffers: two buffers, LB1 holding the previous line and LB2 holding the line before that. Each is a RAM or shift structure of depth LINE_MAX indexed by col_cnt.
  - On de=1 with col_cnt<LINE_MAX: read LB1[col] and LB2[col], then write LB2[col]<=LB1[col] and LB1[col]<=pre_img_y. This is a read-before-write in the same cycle.
  - With col_cnt>=LINE_MAX: no write; col_cnt saturates and the pixel's result is forced to 0.
- Window: a 3x3 register array shifted left on each de=1 pixel.
  - New right column is {LB2 out, LB1 out, current Y} = rows top/mid/bottom.
  - The result is attributed to the pixel whose window bottom-right is the current input.
- Pipeline, latency exactly 5 clk from input sample to post_* for every signal:
  - S1: buffer read and register input Y, col_cnt, row_cnt.
  - S2: window shift.
  - S3: Gx = (p13+2p23+p33) - (p11+2p21+p31) and Gy = (p11+2p12+p13) - (p31+2p32+p33), signed 12b.
  - S4: mag = |Gx|+|Gy|, unsigned 11b. Max value 2040, so no overflow.
  - S5: edge = (mag>=THRESHOLD) && valid, registered.
- Valid/border rule: valid = de && row_cnt>=2 && col_cnt>=2 && col_cnt<LINE_MAX, evaluated at S1 and carried through the pipeline. Invalid positions (first two rows, first two columns, overlong lines) output edge=0.
- Output gating: post_edge_bit and post_img_data are 0 whenever post_frame_de=0.
- Sync delay: vsync, hsync and de each pass through a 5-stage shift register, independent of data validity.
- Simultaneous events:
  - vsync rising edge coinciding with de=1: the row_cnt clear wins and that pixel counts as row 0.
  - de falling edge together with a vsync rising edge: row_cnt clears, no increment.
- Reset mid-frame: behaviour restarts cleanly.
  - row_cnt=0 until the next vsync; rows count from the first de after reset.
  - No spurious edge within the first two rows after reset.

Test Plan:
- Reset with random inputs active -> all outputs 0 during reset and for 5 clk after release; counters at 0.
- 640x480 flat image Y=0x80 -> post_edge_bit=0 for every pixel; post_frame_de pattern equals input de delayed exactly 5 clk.
- Vertical step edge: Y=0 for col<320, Y=255 for col>=320, THRESHOLD=160 -> rows>=2 give 0xFFFFFF at cols 320 and 321 only (|Gx|=1020); all else 0.
- Horizontal step at row 100 -> rows 100 and 101 edge across cols 2..639; rows 0-1 and cols 0-1 always 0.
- Line of 1100 pixels with LINE_MAX=1024 -> cols 1024..1099 output 0, no buffer corruption; next line's edges correct.
- rst_n pulsed low mid-frame (row 200) -> outputs 0 immediately (asynchronously); after the next vsync rising edge, the step-edge response matches the expected pattern.
